// File: rtl/isa_host_pkg.sv
// Shared types and constants for the ISA host-side bus initiator.
// Strobe vectors are active-low, ordered {ior, iow, memr, memw}.
package isa_host_pkg;

  localparam int CNT_W           = 10;
  localparam int SETUP_CYC_DEF   = 5;
  localparam int STROBE_CYC_DEF  = 12;
  localparam int HOLD_CYC_DEF    = 7;
  localparam int TIMEOUT_CYC_DEF = 1023;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_WAIT,
    ST_HOLD
  } state_e;

  // Strobe selection is indexed by {read, io}.
  typedef enum logic [1:0] {
    SEL_MEMW = 2'b00,
    SEL_IOW  = 2'b01,
    SEL_MEMR = 2'b10,
    SEL_IOR  = 2'b11
  } strobe_sel_e;

  function automatic logic [3:0] strobe_lines(input logic read, input logic io);
    logic [3:0] s;
    s = 4'b1111;
    case (strobe_sel_e'({read, io}))
      SEL_MEMW: s = 4'b1110;
      SEL_IOW:  s = 4'b1011;
      SEL_MEMR: s = 4'b1101;
      SEL_IOR:  s = 4'b0111;
      default:  s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/isa_rdy_sync.sv
// Two-flop synchronizer bringing the asynchronous IOCHRDY line into clk.
// Resets to "not ready" so a fresh cycle never exits on stale state.
module isa_rdy_sync (
  input  logic clk,
  input  logic reset,
  input  logic rdy_in,
  output logic rdy_s
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= rdy_in;
      sync_q <= meta_q;
    end
  end

  assign rdy_s = sync_q;

endmodule

// File: rtl/isa_host_master.sv
// ISA bus initiator: one request becomes a setup/strobe/wait/hold bus cycle
// with IOCHRDY wait states and a timeout abort. All bus outputs are registered.
module isa_host_master
  import isa_host_pkg::*;
#(
  parameter int SETUP_CYC   = SETUP_CYC_DEF,
  parameter int STROBE_CYC  = STROBE_CYC_DEF,
  parameter int HOLD_CYC    = HOLD_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_wdata,
  input  logic        req_read,
  input  logic        req_io,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [19:0] bus_a,
  output logic [7:0]  bus_d_out,
  output logic        bus_d_oe,
  input  logic [7:0]  bus_d_in,
  output logic        bus_ior_l,
  output logic        bus_iow_l,
  output logic        bus_memr_l,
  output logic        bus_memw_l,
  output logic        bus_aen,
  input  logic        bus_rdy
);

  logic rdy_s;

  isa_rdy_sync u_rdy_sync (
    .clk    (clk),
    .reset  (reset),
    .rdy_in (bus_rdy),
    .rdy_s  (rdy_s)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             read_q, read_d;
  logic             io_q, io_d;
  logic [19:0]      bus_a_q, bus_a_d;
  logic [7:0]       bus_d_out_q, bus_d_out_d;
  logic             bus_d_oe_q, bus_d_oe_d;
  logic             bus_aen_q, bus_aen_d;
  logic [3:0]       strobe_l_q, strobe_l_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic             req_ready_q, req_ready_d;
  logic             end_strobe;
  logic             timed_out;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wcnt_d      = wcnt_q;
    read_d      = read_q;
    io_d        = io_q;
    bus_a_d     = bus_a_q;
    bus_d_out_d = bus_d_out_q;
    bus_d_oe_d  = bus_d_oe_q;
    bus_aen_d   = bus_aen_q;
    strobe_l_d  = strobe_l_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    req_ready_d = req_ready_q;
    end_strobe  = 1'b0;
    timed_out   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d     = ST_SETUP;
          req_ready_d = 1'b0;
          read_d      = req_read;
          io_d        = req_io;
          bus_a_d     = req_addr;
          bus_d_out_d = req_wdata;
          bus_d_oe_d  = ~req_read;
          bus_aen_d   = 1'b0;
          cnt_d       = CNT_W'(SETUP_CYC - 1);
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d    = ST_STROBE;
          strobe_l_d = strobe_lines(read_q, io_q);
          cnt_d      = CNT_W'(STROBE_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          if (rdy_s) begin
            end_strobe = 1'b1;
          end else begin
            state_d = ST_WAIT;
            wcnt_d  = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WAIT: begin
        // A ready card wins over a timeout landing on the same clock.
        if (rdy_s) begin
          end_strobe = 1'b1;
        end else if (wcnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          end_strobe = 1'b1;
          timed_out  = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          req_ready_d = 1'b1;
          bus_d_oe_d  = 1'b0;
          bus_aen_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (end_strobe) begin
      state_d     = ST_HOLD;
      cnt_d       = CNT_W'(HOLD_CYC - 1);
      strobe_l_d  = 4'b1111;
      rsp_err_d   = timed_out;
      rsp_rdata_d = timed_out ? 8'hFF : (read_q ? bus_d_in : 8'h00);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wcnt_q      <= '0;
      read_q      <= 1'b0;
      io_q        <= 1'b0;
      bus_a_q     <= '0;
      bus_d_out_q <= '0;
      bus_d_oe_q  <= 1'b0;
      bus_aen_q   <= 1'b1;
      strobe_l_q  <= 4'b1111;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      read_q      <= read_d;
      io_q        <= io_d;
      bus_a_q     <= bus_a_d;
      bus_d_out_q <= bus_d_out_d;
      bus_d_oe_q  <= bus_d_oe_d;
      bus_aen_q   <= bus_aen_d;
      strobe_l_q  <= strobe_l_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign bus_a     = bus_a_q;
  assign bus_d_out = bus_d_out_q;
  assign bus_d_oe  = bus_d_oe_q;
  assign bus_aen   = bus_aen_q;
  assign {bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l} = strobe_l_q;

endmodule
